// File: rtl/xsleena_pkg.sv
// xsleena_pkg
//   Shared definitions for the CPU A interrupt controller slice.
//   - Register offsets on CPU A's bus (write side).
//   - Bit positions of the status byte returned on reads.
//   - raster_match(): the line-compare rule for the raster IRQ.
package xsleena_pkg;

  // Write offsets. Offset 5 is where the shared decoder routes CPU B's
  // acknowledge of its own FIRQ. Offsets 6 and 7 are unused.
  localparam logic [2:0] IRQ_ACK_NMI  = 3'd0;
  localparam logic [2:0] IRQ_ACK_FIRQ = 3'd1;
  localparam logic [2:0] IRQ_ACK_IRQ  = 3'd2;
  localparam logic [2:0] FIRQB_SET    = 3'd3;
  localparam logic [2:0] IRQ_EN_REG   = 3'd4;
  localparam logic [2:0] FIRQB_ACK    = 3'd5;

  // Bit positions in the status byte.
  localparam int DOUT_NMI_BIT   = 0;
  localparam int DOUT_FIRQ_BIT  = 1;
  localparam int DOUT_IRQ_BIT   = 2;
  localparam int DOUT_FIRQB_BIT = 3;
  localparam int DOUT_VBL_BIT   = 7;

  // Bit positions in the enable register.
  localparam int EN_NMI_BIT  = 0;
  localparam int EN_FIRQ_BIT = 1;
  localparam int EN_IRQ_BIT  = 2;

  // The raster IRQ uses only the low four line bits, so the line count can
  // wrap freely without affecting anything beyond this compare.
  function automatic logic raster_match(input logic [3:0] vpos_lo,
                                        input logic [3:0] mask,
                                        input logic [3:0] val);
    return ((vpos_lo & mask) == val);
  endfunction

endpackage

// File: rtl/xsleena_irq_latch.sv
// xsleena_irq_latch
//   One interrupt-pending flag. Set and clear may arrive in the same cycle;
//   the set wins so an event is never lost to a racing acknowledge.
// Ports:
//   HCLK  in   system clock
//   RSTn  in   asynchronous active-low reset
//   set   in   set request (single cycle)
//   clr   in   clear request (single cycle)
//   q     out  pending flag
module xsleena_irq_latch (
  input  logic HCLK,
  input  logic RSTn,
  input  logic set,
  input  logic clr,
  output logic q
);

  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn)
      q <= 1'b0;
    else if (set)
      q <= 1'b1;
    else if (clr)
      q <= 1'b0;
  end

endmodule

// File: rtl/xsleena_cpua_irq_ctrl.sv
// xsleena_cpua_irq_ctrl
//   Interrupt controller for main CPU A (MC6809E). Builds nNMI (VBL rising
//   edge), nIRQ (raster line match) and nFIRQ (request from CPU B), plus the
//   FIRQ line towards CPU B. Each source is latched and cleared by a CPU
//   write to its acknowledge offset.
// Ports:
//   HCLK      in   system clock
//   RSTn      in   asynchronous active-low reset
//   VPOS      in   vertical line count (9)
//   LINE_STB  in   start-of-line pulse
//   VBL       in   vertical blank level
//   FIRQ_REQ  in   FIRQ request pulse from CPU B
//   BUS_EN    in   CPU bus cycle qualifier
//   CS        in   register block select
//   A         in   register offset (3)
//   RnW       in   CPU read/not-write
//   DIN       in   CPU write data (8)
//   DOUT      out  status read data (8)
//   nNMI, nFIRQ, nIRQ  out  CPU A interrupt lines, active low
//   nFIRQ_B   out  FIRQ to CPU B, active low
module xsleena_cpua_irq_ctrl
  import xsleena_pkg::*;
#(
  parameter logic [3:0] IRQ_LINE_MASK  = 4'hF,
  parameter logic [3:0] IRQ_LINE_VAL   = 4'h8,
  parameter logic       VBL_NMI_EN_RST = 1'b0
) (
  input  logic       HCLK,
  input  logic       RSTn,
  input  logic [8:0] VPOS,
  input  logic       LINE_STB,
  input  logic       VBL,
  input  logic       FIRQ_REQ,
  input  logic       BUS_EN,
  input  logic       CS,
  input  logic [2:0] A,
  input  logic       RnW,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       nNMI,
  output logic       nFIRQ,
  output logic       nIRQ,
  output logic       nFIRQ_B
);

  logic [2:0] en;
  logic       vbl_q;
  logic       wr;
  logic       nmi_set, firq_set, irq_set;
  logic       nmi_p, firq_p, irq_p, firqb_p;

  // The upper line bits and write-data bits play no part in this block.
  logic unused_bits;
  assign unused_bits = ^{VPOS[8:4], DIN[7:3]};

  assign wr = BUS_EN & CS & ~RnW;

  // Enable register and the VBL history used for edge detection. Because
  // vbl_q resets to 0, a VBL already high at reset release counts as a
  // rising edge and yields one NMI if that source is enabled.
  always_ff @(posedge HCLK or negedge RSTn) begin
    if (!RSTn) begin
      en    <= {2'b00, VBL_NMI_EN_RST};
      vbl_q <= 1'b0;
    end else begin
      vbl_q <= VBL;
      if (wr && (A == IRQ_EN_REG))
        en <= DIN[2:0];
    end
  end

  // Event qualification. Disabled events are dropped on the floor; nothing
  // is remembered for a later enable.
  always_comb begin
    nmi_set  = VBL & ~vbl_q & en[EN_NMI_BIT];
    firq_set = FIRQ_REQ & en[EN_FIRQ_BIT];
    irq_set  = LINE_STB & en[EN_IRQ_BIT] &
               raster_match(VPOS[3:0], IRQ_LINE_MASK, IRQ_LINE_VAL);
  end

  xsleena_irq_latch u_nmi (
    .HCLK (HCLK), .RSTn (RSTn),
    .set  (nmi_set),
    .clr  (wr && (A == IRQ_ACK_NMI)),
    .q    (nmi_p)
  );

  xsleena_irq_latch u_firq (
    .HCLK (HCLK), .RSTn (RSTn),
    .set  (firq_set),
    .clr  (wr && (A == IRQ_ACK_FIRQ)),
    .q    (firq_p)
  );

  xsleena_irq_latch u_irq (
    .HCLK (HCLK), .RSTn (RSTn),
    .set  (irq_set),
    .clr  (wr && (A == IRQ_ACK_IRQ)),
    .q    (irq_p)
  );

  // CPU A raises CPU B's FIRQ at one offset and CPU B clears it at another.
  xsleena_irq_latch u_firqb (
    .HCLK (HCLK), .RSTn (RSTn),
    .set  (wr && (A == FIRQB_SET)),
    .clr  (wr && (A == FIRQB_ACK)),
    .q    (firqb_p)
  );

  // The latches are the output registers; only an inversion follows.
  assign nNMI    = ~nmi_p;
  assign nFIRQ   = ~firq_p;
  assign nIRQ    = ~irq_p;
  assign nFIRQ_B = ~firqb_p;

  // Status is readable at every offset and reads as zero when deselected.
  always_comb begin
    DOUT = 8'h00;
    if (CS && RnW) begin
      DOUT[DOUT_VBL_BIT]   = VBL;
      DOUT[DOUT_FIRQB_BIT] = firqb_p;
      DOUT[DOUT_IRQ_BIT]   = irq_p;
      DOUT[DOUT_FIRQ_BIT]  = firq_p;
      DOUT[DOUT_NMI_BIT]   = nmi_p;
    end
  end

endmodule

// File: tb/tb_xsleena_cpua_irq_ctrl.sv
// tb_xsleena_cpua_irq_ctrl
//   Directed and randomized checks of the CPU A interrupt controller against
//   a behavioural model of pending flags and enables.
module tb_xsleena_cpua_irq_ctrl;

  localparam logic [3:0] LINE_MASK = 4'hF;
  localparam logic [3:0] LINE_VAL  = 4'h8;

  logic       HCLK = 1'b0;
  logic       RSTn;
  logic [8:0] VPOS;
  logic       LINE_STB, VBL, FIRQ_REQ, BUS_EN, CS, RnW;
  logic [2:0] A;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       nNMI, nFIRQ, nIRQ, nFIRQ_B;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       vbl;
    logic       line_stb;
    logic [8:0] vpos;
    logic       firq_req;
    logic       bus_en;
    logic       cs;
    logic [2:0] a;
    logic       rnw;
    logic [7:0] din;
  } stim_t;

  // Model state: pending[0..3] = NMI, FIRQ, IRQ, FIRQ-to-B.
  bit       pending [4];
  bit [2:0] m_en;
  bit       m_vbl_prev;

  xsleena_cpua_irq_ctrl #(
    .IRQ_LINE_MASK  (LINE_MASK),
    .IRQ_LINE_VAL   (LINE_VAL),
    .VBL_NMI_EN_RST (1'b0)
  ) dut (
    .HCLK     (HCLK),
    .RSTn     (RSTn),
    .VPOS     (VPOS),
    .LINE_STB (LINE_STB),
    .VBL      (VBL),
    .FIRQ_REQ (FIRQ_REQ),
    .BUS_EN   (BUS_EN),
    .CS       (CS),
    .A        (A),
    .RnW      (RnW),
    .DIN      (DIN),
    .DOUT     (DOUT),
    .nNMI     (nNMI),
    .nFIRQ    (nFIRQ),
    .nIRQ     (nIRQ),
    .nFIRQ_B  (nFIRQ_B)
  );

  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idleStim();
    stim_t s;
    s.vbl = VBL; s.line_stb = 1'b0; s.vpos = VPOS; s.firq_req = 1'b0;
    s.bus_en = 1'b0; s.cs = 1'b0; s.a = 3'd0; s.rnw = 1'b1; s.din = 8'h00;
    return s;
  endfunction

  function automatic stim_t writeStim(input logic [2:0] a, input logic [7:0] d);
    stim_t s;
    s = idleStim();
    s.bus_en = 1'b1; s.cs = 1'b1; s.rnw = 1'b0; s.a = a; s.din = d;
    return s;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 4; i++) pending[i] = 1'b0;
    m_en = 3'b000;
    m_vbl_prev = 1'b0;
  endtask

  // One clock of the controller's rules applied to the sampled inputs.
  task automatic modelStep(input stim_t s);
    bit wr;
    bit sets [4];
    bit clrs [4];
    wr = s.bus_en && s.cs && !s.rnw;
    sets[0] = s.vbl && !m_vbl_prev && m_en[0];
    sets[1] = s.firq_req && m_en[1];
    sets[2] = s.line_stb && m_en[2] && (((s.vpos % 16) & LINE_MASK) == LINE_VAL);
    sets[3] = wr && (s.a == 3);
    clrs[0] = wr && (s.a == 0);
    clrs[1] = wr && (s.a == 1);
    clrs[2] = wr && (s.a == 2);
    clrs[3] = wr && (s.a == 5);
    for (int i = 0; i < 4; i++)
      if (sets[i]) pending[i] = 1'b1;
      else if (clrs[i]) pending[i] = 1'b0;
    if (wr && s.a == 4) m_en = s.din[2:0];
    m_vbl_prev = s.vbl;
  endtask

  task automatic checkAll(input stim_t s);
    logic [7:0] exp_dout;
    exp_dout = 8'h00;
    if (s.cs && s.rnw)
      exp_dout = {s.vbl, 3'b000, pending[3], pending[2], pending[1], pending[0]};
    checkOutput("nNMI",    nNMI,    !pending[0]);
    checkOutput("nFIRQ",   nFIRQ,   !pending[1]);
    checkOutput("nIRQ",    nIRQ,    !pending[2]);
    checkOutput("nFIRQ_B", nFIRQ_B, !pending[3]);
    checkOutput("DOUT",    DOUT,    exp_dout);
  endtask

  // Drive one cycle of inputs (between edges), clock it, then check 1ns later.
  task automatic applyStimulus(input stim_t s);
    VBL = s.vbl; LINE_STB = s.line_stb; VPOS = s.vpos; FIRQ_REQ = s.firq_req;
    BUS_EN = s.bus_en; CS = s.cs; A = s.a; RnW = s.rnw; DIN = s.din;
    @(posedge HCLK);
    if (!RSTn) modelReset();
    else modelStep(s);
    #1;
    checkAll(s);
  endtask

  initial begin
    stim_t s;
    RSTn = 1'b0; VBL = 1'b0; VPOS = 9'd0;
    LINE_STB = 1'b0; FIRQ_REQ = 1'b0; BUS_EN = 1'b0; CS = 1'b0;
    A = 3'd0; RnW = 1'b1; DIN = 8'h00;
    modelReset();

    // Reset held while everything toggles.
    for (int i = 0; i < 4; i++) begin
      s = idleStim();
      s.vbl = i[0]; s.line_stb = 1'b1; s.vpos = 9'h008; s.firq_req = 1'b1;
      applyStimulus(s);
    end
    s = idleStim(); s.vbl = 1'b0;
    applyStimulus(s);
    checkOutput("rst_nNMI", nNMI, 1'b1);
    checkOutput("rst_DOUT", DOUT, 8'h00);
    RSTn = 1'b1;
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("rel_nNMI", nNMI, 1'b1);
    checkOutput("rel_nFIRQ_B", nFIRQ_B, 1'b1);

    // NMI on VBL rising edge, ack, no retrigger while VBL stays high.
    applyStimulus(writeStim(3'd4, 8'h01));
    s = idleStim(); s.vbl = 1'b1;
    applyStimulus(s);
    checkOutput("nmi_set", nNMI, 1'b0);
    applyStimulus(writeStim(3'd0, 8'hA5));
    checkOutput("nmi_ack", nNMI, 1'b1);
    applyStimulus(idleStim());
    applyStimulus(idleStim());
    checkOutput("nmi_noretrig", nNMI, 1'b1);
    s = idleStim(); s.vbl = 1'b0;
    applyStimulus(s);

    // Raster IRQ.
    applyStimulus(writeStim(3'd4, 8'h04));
    s = idleStim(); s.line_stb = 1'b1; s.vpos = 9'h008;
    applyStimulus(s);
    checkOutput("irq_line8", nIRQ, 1'b0);
    applyStimulus(writeStim(3'd2, 8'h00));
    checkOutput("irq_ack", nIRQ, 1'b1);
    s = idleStim(); s.line_stb = 1'b1; s.vpos = 9'h009;
    applyStimulus(s);
    checkOutput("irq_line9", nIRQ, 1'b1);
    s = idleStim(); s.line_stb = 1'b1; s.vpos = 9'h1F8;
    applyStimulus(s);
    checkOutput("irq_line1f8", nIRQ, 1'b0);
    applyStimulus(writeStim(3'd2, 8'h00));

    // Masking: disabled FIRQ is discarded.
    applyStimulus(writeStim(3'd4, 8'h00));
    s = idleStim(); s.firq_req = 1'b1;
    applyStimulus(s);
    checkOutput("firq_masked", nFIRQ, 1'b1);
    applyStimulus(writeStim(3'd4, 8'h02));
    applyStimulus(idleStim());
    checkOutput("firq_nopend", nFIRQ, 1'b1);

    // Collision: set beats clear.
    s = idleStim(); s.firq_req = 1'b1;
    applyStimulus(s);
    s = writeStim(3'd1, 8'h00); s.firq_req = 1'b1;
    applyStimulus(s);
    checkOutput("firq_collide", nFIRQ, 1'b0);
    applyStimulus(writeStim(3'd1, 8'h00));
    checkOutput("firq_ack", nFIRQ, 1'b1);

    // Cross-CPU FIRQ and readback.
    applyStimulus(writeStim(3'd3, 8'h00));
    checkOutput("firqb_set", nFIRQ_B, 1'b0);
    s = idleStim(); s.cs = 1'b1; s.rnw = 1'b1; s.a = 3'd6;
    applyStimulus(s);
    checkOutput("readback", DOUT, 8'h08);
    applyStimulus(writeStim(3'd5, 8'h00));
    checkOutput("firqb_ack", nFIRQ_B, 1'b1);
    s = writeStim(3'd3, 8'h00); s.bus_en = 1'b0;
    applyStimulus(s);
    checkOutput("firqb_noen", nFIRQ_B, 1'b1);

    // Asynchronous reset mid-operation.
    applyStimulus(writeStim(3'd3, 8'h00));
    #3;
    RSTn = 1'b0;
    #1;
    modelReset();
    checkOutput("async_nFIRQ_B", nFIRQ_B, 1'b1);
    s = idleStim();
    applyStimulus(s);
    RSTn = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      s = idleStim();
      if ($urandom_range(0, 5) == 0) s.vbl = ~VBL;
      s.line_stb = ($urandom_range(0, 3) == 0);
      s.vpos     = 9'($urandom_range(0, 511));
      s.firq_req = ($urandom_range(0, 5) == 0);
      s.cs       = ($urandom_range(0, 2) == 0);
      s.bus_en   = ($urandom_range(0, 1) == 0);
      s.rnw      = ($urandom_range(0, 1) == 0);
      s.a        = 3'($urandom_range(0, 7));
      s.din      = 8'($urandom_range(0, 255));
      applyStimulus(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
